// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder
// Description : Mode-0 single-lane SPI flash target, oversampled on clk.
//               Serves 0x03 reads from a byte memory port and 0x9F JEDEC ID.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
    parameter int          ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_csb,
    input  logic                 spi_clk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic                 mem_rd,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_byte,
    output logic                 active
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_ID     = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        csb_s1_q, csb_s2_q, csb_p_q;
    logic        sck_s1_q, sck_s2_q, sck_p_q;
    logic        mosi_s1_q, mosi_s2_q;
    logic [1:0]  settle_q;
    logic        armed_q, armed_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [22:0] shift_q, shift_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  out_q, out_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic [1:0]  id_idx_q, id_idx_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        mem_rd_q, mem_rd_d;
    logic        cap_q;
    logic        cmd_valid_q, cmd_valid_d;

    logic        sck_rise, sck_fall, csb_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            csb_s1_q  <= 1'b1;
            csb_s2_q  <= 1'b1;
            csb_p_q   <= 1'b1;
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_p_q   <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            settle_q  <= 2'd0;
        end else begin
            csb_s1_q  <= spi_csb;
            csb_s2_q  <= csb_s1_q;
            csb_p_q   <= csb_s2_q;
            sck_s1_q  <= spi_clk;
            sck_s2_q  <= sck_s1_q;
            sck_p_q   <= sck_s2_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
            settle_q  <= settle_q[1] ? settle_q : settle_q + 2'd1;
        end
    end

    assign sck_rise = sck_s2_q & ~sck_p_q;
    assign sck_fall = ~sck_s2_q & sck_p_q;
    assign csb_fall = csb_p_q & ~csb_s2_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        out_d       = out_q;
        cmd_byte_d  = cmd_byte_q;
        id_idx_d    = id_idx_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        mem_rd_d    = 1'b0;
        cmd_valid_d = 1'b0;
        // Synchronizer reset values read as a deselected bus, so a select held
        // low through reset must first be seen high once the pipeline settles.
        armed_d     = armed_q | (settle_q[1] & csb_s2_q);

        if (cap_q) begin
            out_d = mem_rdata;
        end

        if (csb_s2_q) begin
            state_d   = S_IDLE;
            bit_cnt_d = 5'd0;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bit_cnt_d = 5'd0;
                    if (armed_q && csb_fall) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    if (sck_rise) begin
                        shift_d   = {shift_q[21:0], mosi_s2_q};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d   = 5'd0;
                            cmd_byte_d  = {shift_q[6:0], mosi_s2_q};
                            cmd_valid_d = 1'b1;
                            case (cmd_byte_d)
                                8'h03:   state_d = S_ADDR;
                                8'h9F: begin
                                    state_d  = S_ID;
                                    id_idx_d = 2'd0;
                                    out_d    = JEDEC_ID[23:16];
                                end
                                default: state_d = S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (sck_rise) begin
                        shift_d   = {shift_q[21:0], mosi_s2_q};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            addr_d    = {shift_q, mosi_s2_q};
                            mem_rd_d  = 1'b1;
                            state_d   = S_DATA;
                        end
                    end
                end
                S_DATA, S_ID: begin
                    if (sck_fall) begin
                        miso_d = out_q[7];
                        out_d  = {out_q[6:0], 1'b0};
                        oe_d   = 1'b1;
                    end else if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            if (state_q == S_DATA) begin
                                addr_d   = addr_q + 24'd1;
                                mem_rd_d = 1'b1;
                            end else begin
                                if (id_idx_q != 2'd3) begin
                                    id_idx_d = id_idx_q + 2'd1;
                                end
                                case (id_idx_d)
                                    2'd1:    out_d = JEDEC_ID[15:8];
                                    2'd2:    out_d = JEDEC_ID[7:0];
                                    default: out_d = 8'h00;
                                endcase
                            end
                        end
                    end
                end
                S_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 23'd0;
            addr_q      <= 24'd0;
            out_q       <= 8'd0;
            cmd_byte_q  <= 8'd0;
            id_idx_q    <= 2'd0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            mem_rd_q    <= 1'b0;
            cap_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            out_q       <= out_d;
            cmd_byte_q  <= cmd_byte_d;
            id_idx_q    <= id_idx_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            mem_rd_q    <= mem_rd_d;
            cap_q       <= mem_rd_q;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_rd      = mem_rd_q;
    assign mem_addr    = addr_q[ADDR_BITS-1:0];
    assign cmd_valid   = cmd_valid_q;
    assign cmd_byte    = cmd_byte_q;
    assign active      = ~csb_s2_q;

endmodule
`default_nettype wire
